// File: rtl/mem_port_arbiter.sv
// Single-ported SRAM arbiter shared by the IF (fetch) and MEM (load/store) stages.
// Each access sits WAIT_CYCLES cycles in BUSY, then the owner gets a single-cycle ready pulse in DONE.
module mem_port_arbiter #(
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int WAIT_CYCLES = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_ready,
    input  logic              mem_rd_en,
    input  logic              mem_wr_en,
    input  logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_wdata,
    output logic [DATA_W-1:0] mem_rdata,
    output logic              mem_ready,
    output logic              freeze_if,
    output logic              stall_mem,
    output logic              sram_en,
    output logic              sram_we,
    output logic [ADDR_W-1:0] sram_addr,
    output logic [DATA_W-1:0] sram_wdata,
    input  logic [DATA_W-1:0] sram_rdata
);

    localparam int                CNT_W    = $clog2(WAIT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(WAIT_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
    typedef enum logic {OWN_IF, OWN_MEM} owner_t;

    state_t           state, state_nxt;
    owner_t           owner, last_owner;
    logic [CNT_W-1:0] cnt;
    logic             mem_pend;
    logic             grant_if, grant_mem;
    logic             busy_last;

    assign mem_pend  = mem_rd_en | mem_wr_en;
    assign freeze_if = if_req & ~if_ready;
    assign stall_mem = mem_pend & ~mem_ready;

    always_ff @(posedge clk) begin
        if (!rst) state <= IDLE;
        else      state <= state_nxt;
    end

    // Requests are only looked at in IDLE; DONE never grants, so a still-held
    // request that just completed is not issued a second time.
    always_comb begin
        state_nxt = state;
        grant_if  = 1'b0;
        grant_mem = 1'b0;
        busy_last = 1'b0;
        case (state)
            IDLE: begin
                if (mem_pend && if_req) begin
                    if (last_owner == OWN_MEM) grant_if  = 1'b1;
                    else                       grant_mem = 1'b1;
                end else if (mem_pend) begin
                    grant_mem = 1'b1;
                end else if (if_req) begin
                    grant_if = 1'b1;
                end
                if (grant_if || grant_mem) state_nxt = BUSY;
            end
            BUSY: begin
                if (cnt == '0) begin
                    busy_last = 1'b1;
                    state_nxt = DONE;
                end
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            owner      <= OWN_IF;
            last_owner <= OWN_IF;
            cnt        <= '0;
            sram_en    <= 1'b0;
            sram_we    <= 1'b0;
            sram_addr  <= '0;
            sram_wdata <= '0;
            if_rdata   <= '0;
            mem_rdata  <= '0;
            if_ready   <= 1'b0;
            mem_ready  <= 1'b0;
        end else begin
            if_ready  <= busy_last && (owner == OWN_IF);
            mem_ready <= busy_last && (owner == OWN_MEM);
            if (grant_if || grant_mem) begin
                sram_en    <= 1'b1;
                // rd and wr both high is illegal; it resolves to a write
                sram_we    <= grant_mem && mem_wr_en;
                sram_addr  <= grant_mem ? mem_addr : if_addr;
                if (grant_mem && mem_wr_en) sram_wdata <= mem_wdata;
                owner      <= grant_mem ? OWN_MEM : OWN_IF;
                last_owner <= grant_mem ? OWN_MEM : OWN_IF;
                cnt        <= CNT_LOAD;
            end else if (state == BUSY) begin
                if (busy_last) begin
                    sram_en <= 1'b0;
                    sram_we <= 1'b0;
                    if (!sram_we) begin
                        if (owner == OWN_IF) if_rdata  <= sram_rdata;
                        else                 mem_rdata <= sram_rdata;
                    end
                end else begin
                    cnt <= cnt - CNT_W'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter (WAIT_CYCLES=3): reset, fetch, store,
// round-robin tie, flush and reset during an access.
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_req;
    logic [31:0] if_addr;
    logic [31:0] if_rdata;
    logic        if_ready;
    logic        mem_rd_en;
    logic        mem_wr_en;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_ready;
    logic        freeze_if;
    logic        stall_mem;
    logic        sram_en;
    logic        sram_we;
    logic [31:0] sram_addr;
    logic [31:0] sram_wdata;
    logic [31:0] sram_rdata;

    int n_cmp = 0;
    int n_err = 0;

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .WAIT_CYCLES(3)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ready(if_ready),
        .mem_rd_en(mem_rd_en), .mem_wr_en(mem_wr_en), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
        .freeze_if(freeze_if), .stall_mem(stall_mem),
        .sram_en(sram_en), .sram_we(sram_we), .sram_addr(sram_addr),
        .sram_wdata(sram_wdata), .sram_rdata(sram_rdata)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance to the next cycle; outputs are sampled 1 ns after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b0; if_req = 1'b1; if_addr = '0;
        mem_rd_en = 1'b0; mem_wr_en = 1'b0; mem_addr = '0; mem_wdata = '0; sram_rdata = '0;

        // Reset held two cycles with a pending fetch
        tick(); tick();
        check("rst_sram_en",  32'(sram_en), 32'd0);
        check("rst_sram_we",  32'(sram_we), 32'd0);
        check("rst_if_ready", 32'(if_ready), 32'd0);
        check("rst_freeze",   32'(freeze_if), 32'd1);
        check("rst_if_rdata", if_rdata, 32'h0);
        check("rst_mem_rdata", mem_rdata, 32'h0);
        check("rst_sram_addr", sram_addr, 32'h0);

        // Fetch: cycle 0 is now
        rst = 1'b1; if_addr = 32'h10; sram_rdata = 32'hE3A01005;
        for (int c = 1; c <= 3; c++) begin
            tick();
            check("fetch_en",    32'(sram_en), 32'd1);
            check("fetch_addr",  sram_addr, 32'h10);
            check("fetch_we",    32'(sram_we), 32'd0);
            check("fetch_rdy",   32'(if_ready), 32'd0);
            check("fetch_frz",   32'(freeze_if), 32'd1);
        end
        tick();
        check("fetch_rdy4",  32'(if_ready), 32'd1);
        check("fetch_data",  if_rdata, 32'hE3A01005);
        check("fetch_frz4",  32'(freeze_if), 32'd0);
        check("fetch_en4",   32'(sram_en), 32'd0);
        if_req = 1'b0;
        tick();
        check("fetch_rdy5",  32'(if_ready), 32'd0);
        check("fetch_en5",   32'(sram_en), 32'd0);

        // Store: cycle 0 is now
        mem_wr_en = 1'b1; mem_addr = 32'h400; mem_wdata = 32'hDEADBEEF; sram_rdata = 32'h12345678;
        for (int c = 1; c <= 3; c++) begin
            tick();
            check("st_we",    32'(sram_we), 32'd1);
            check("st_addr",  sram_addr, 32'h400);
            check("st_wdata", sram_wdata, 32'hDEADBEEF);
            check("st_stall", 32'(stall_mem), 32'd1);
        end
        tick();
        check("st_rdy4",   32'(mem_ready), 32'd1);
        check("st_stall4", 32'(stall_mem), 32'd0);
        check("st_rdata",  mem_rdata, 32'h0);
        check("st_we4",    32'(sram_we), 32'd0);
        mem_wr_en = 1'b0;
        tick();
        check("st_rdy5",   32'(mem_ready), 32'd0);

        // Tie after reset: MEM first, then IF, then MEM again
        rst = 1'b0;
        tick();
        rst = 1'b1;
        if_req = 1'b1; if_addr = 32'h20; mem_rd_en = 1'b1; mem_addr = 32'h200; sram_rdata = 32'hAAAA5555;
        tick();
        check("tie_first_addr", sram_addr, 32'h200);
        tick(); tick(); tick();
        check("tie_mem_rdy4",  32'(mem_ready), 32'd1);
        check("tie_mem_data",  mem_rdata, 32'hAAAA5555);
        check("tie_if_rdy4",   32'(if_ready), 32'd0);
        check("tie_frz4",      32'(freeze_if), 32'd1);
        tick();
        sram_rdata = 32'h0BADF00D;
        check("tie_en5",       32'(sram_en), 32'd0);
        check("tie_mem_rdy5",  32'(mem_ready), 32'd0);
        tick();
        check("tie_second_addr", sram_addr, 32'h20);
        check("tie_second_en",   32'(sram_en), 32'd1);
        tick(); tick(); tick();
        check("tie_if_rdy9",   32'(if_ready), 32'd1);
        check("tie_if_data",   if_rdata, 32'h0BADF00D);
        check("tie_mem_rdy9",  32'(mem_ready), 32'd0);
        check("tie_mem_hold",  mem_rdata, 32'hAAAA5555);
        tick(); tick();
        check("tie_third_addr", sram_addr, 32'h200);
        if_req = 1'b0; mem_rd_en = 1'b0;
        tick(); tick(); tick();
        check("tie_mem_rdy14", 32'(mem_ready), 32'd1);
        tick();

        // Flush: fetch withdrawn in cycle 2, load waiting from cycle 2
        if_req = 1'b1; if_addr = 32'h30; sram_rdata = 32'h11112222;
        tick(); tick();
        if_req = 1'b0; mem_rd_en = 1'b1; mem_addr = 32'h300;
        tick();
        check("fl_addr3",  sram_addr, 32'h30);
        tick();
        check("fl_rdy4",   32'(if_ready), 32'd1);
        check("fl_data",   if_rdata, 32'h11112222);
        check("fl_frz4",   32'(freeze_if), 32'd0);
        tick();
        check("fl_en5",    32'(sram_en), 32'd0);
        tick();
        check("fl_en6",    32'(sram_en), 32'd1);
        check("fl_addr6",  sram_addr, 32'h300);

        // Load now in its cycle 1; reset in cycle 2
        tick();
        rst = 1'b0;
        tick();
        check("mr_en3",    32'(sram_en), 32'd0);
        check("mr_we3",    32'(sram_we), 32'd0);
        rst = 1'b1; mem_rd_en = 1'b0;
        for (int c = 3; c <= 7; c++) begin
            check("mr_no_rdy", 32'(mem_ready), 32'd0);
            tick();
        end

        // Normal load after the aborted one
        mem_rd_en = 1'b1; mem_addr = 32'h500; sram_rdata = 32'hCAFE0001;
        tick();
        check("ld_addr",   sram_addr, 32'h500);
        tick(); tick(); tick();
        check("ld_rdy",    32'(mem_ready), 32'd1);
        check("ld_data",   mem_rdata, 32'hCAFE0001);
        mem_rd_en = 1'b0;
        tick();
        check("ld_rdy5",   32'(mem_ready), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-ported, fixed-latency SRAM between the IF stage (instruction fetch, read-only) and the MEM stage (data load/store).
- Sequences each access and returns one-cycle ready pulses to the owning requester.
- Drives freeze_if and stall_mem, which the top level routes to the IF freeze input and to the ID/EXE/MEM pipeline-register enables.

Parameters:
- ADDR_W, 32: address width.
- DATA_W, 32: data width.
- WAIT_CYCLES, 3: SRAM access latency in cycles. Legal range is 1..15.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-low reset.
- if_req  in  1  IF fetch request; held until if_ready.
- if_addr  in  ADDR_W  fetch address.
- if_rdata  out  DATA_W  fetched instruction.
- if_ready  out  1  one-cycle completion pulse for IF.
- mem_rd_en  in  1  MEM load request.
- mem_wr_en  in  1  MEM store request; mutually exclusive with mem_rd_en.
- mem_addr  in  ADDR_W  data address.
- mem_wdata  in  DATA_W  store data.
- mem_rdata  out  DATA_W  load data.
- mem_ready  out  1  one-cycle completion pulse for MEM.
- freeze_if  out  1  combinational: if_req & ~if_ready.
- stall_mem  out  1  combinational: (mem_rd_en | mem_wr_en) & ~mem_ready.
- sram_en  out  1  access in progress.
- sram_we  out  1  write strobe.
- sram_addr  out  ADDR_W  SRAM address.
- sram_wdata  out  DATA_W  SRAM write data.
- sram_rdata  in  DATA_W  SRAM read data; valid at the end of the WAIT_CYCLES-th BUSY cycle.

Behaviour:
- Clock and reset: single clock, clk. rst is synchronous and active-low; when rst=0 at a rising edge, every register is reset.
- Reset values:
  - state=IDLE, cnt=0, owner=IF, last_owner=IF.
  - sram_en=0, sram_we=0, sram_addr=0, sram_wdata=0.
  - if_rdata=0, mem_rdata=0, if_ready=0, mem_ready=0.
- States: IDLE, BUSY, DONE.
- IDLE, arbitration:
  - MEM pending only: grant MEM.
  - IF pending only: grant IF.
  - Both pending: grant the side not equal to last_owner (round-robin). After reset this means MEM wins the first tie.
  - On grant: register sram_addr, sram_wdata (MEM write only) and sram_we (= grant to MEM & mem_wr_en); set sram_en=1, owner=grantee, last_owner=grantee, cnt=WAIT_CYCLES-1; go to BUSY.
  - No request: stay in IDLE, sram_en=0.
- BUSY:
  - sram_en, sram_we, sram_addr and sram_wdata hold stable.
  - Input requests are ignored.
  - cnt decrements each cycle. At cnt==0, go to DONE; if the access is a read, latch sram_rdata into the owner's rdata register.
- DONE:
  - sram_en=0, sram_we=0.
  - The owner's ready output is 1 for exactly this cycle; go to IDLE.
  - Requests seen in DONE are never granted. This prevents re-issuing the just-completed, still-held request.
- Latency: a request sampled in IDLE at cycle 0 gives BUSY in cycles 1..WAIT_CYCLES and ready in cycle WAIT_CYCLES+1. The next grant is possible at cycle WAIT_CYCLES+2.
- Read data: if_rdata and mem_rdata change only on completion of a read by their owner and hold otherwise. A store never modifies mem_rdata.
- Withdrawn request: if if_req drops during BUSY (branch flush), the access still completes and if_ready still pulses. IF ignores it.
- Illegal input: mem_rd_en=mem_wr_en=1 is illegal. The block treats it as a write.
- Reset mid-access: the state returns to IDLE, sram_en and sram_we go to 0 the next cycle, and no ready pulse is produced.
- WAIT_CYCLES=1: a single BUSY cycle; ready arrives in cycle 2.
- Counter width: clog2(WAIT_CYCLES+1). No wrap occurs because the counter is reloaded on every grant.

Test Plan:
- Reset: hold rst=0 for 2 cycles with if_req=1 → sram_en=0, if_ready=0, freeze_if=1, all data outputs 0.
- IF fetch, WAIT_CYCLES=3: if_req=1, if_addr=0x10 at cycle 0, SRAM returns 0xE3A01005 → sram_en=1 with sram_addr=0x10 in cycles 1–3; if_ready=1 and if_rdata=0xE3A01005 in cycle 4 only; freeze_if=0 in cycle 4.
- Store: mem_wr_en=1, addr=0x400, wdata=0xDEADBEEF → sram_we=1 in cycles 1–3; mem_ready pulses in cycle 4; mem_rdata unchanged.
- Simultaneous requests after reset: if_req and mem_rd_en both asserted and held → MEM is granted first (ready in cycle 4), IF is granted in cycle 5 (ready in cycle 9); ties keep alternating.
- Flush: if_req dropped in cycle 2 of a fetch → access completes, if_ready pulses in cycle 4, a new request is granted no earlier than cycle 5.
- Reset mid-access: rst=0 in cycle 2 of a load → sram_en=0 in cycle 3, mem_ready never pulses, a new request is granted normally afterwards.
